// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory req/ack fetch bus
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with PC, req/ack fetch and timeout retry
// Optional sticky misalignment flag: define IF_ALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             i_npc,
    input  logic                    i_advance,
    if_fetch_unit_if.master         bus,
    output logic [31:0]             o_pc,
    output logic [31:0]             o_instr,
    output logic                    o_instr_valid,
    output logic                    o_fetch_err,
    output logic                    o_pc_misalign
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_req, w_req_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_err, w_err_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        w_timeout;

    assign w_timeout = (r_cnt == LP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 8'h0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.imem_ack)   w_state_nxt = S_VALID;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_VALID: if (i_advance) w_state_nxt = S_WAIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Ack is checked before timeout so a last-cycle ack wins over the error.
    always_comb begin
        w_req_nxt   = r_req;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 1'b1;
                w_cnt_nxt = 8'h0;
            end
            S_WAIT: begin
                if (bus.imem_ack) begin
                    w_instr_nxt = bus.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_req_nxt   = 1'b0;
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
                    w_req_nxt = 1'b0;
                    w_cnt_nxt = 8'h0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'h1;
                end
            end
            S_VALID: begin
                if (i_advance) begin
                    w_pc_nxt    = {i_npc[31:2], 2'b00};
                    w_valid_nxt = 1'b0;
                    w_req_nxt   = 1'b1;
                    w_cnt_nxt   = 8'h0;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

`ifdef IF_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_misalign <= 1'b0;
        else if (r_state == S_VALID && i_advance && i_npc[1:0] != 2'b00)
            r_misalign <= 1'b1;
    end

    assign o_pc_misalign = r_misalign;
`else
    logic w_unused_npc_lo;

    assign w_unused_npc_lo = ^i_npc[1:0];
    assign o_pc_misalign   = 1'b0;
`endif

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_fetch_err   = r_err;
endmodule
